// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer for a 4-bit-opcode accumulator datapath
module instruction_sequencer #(
    parameter int PC_W        = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    input  logic            zero,
    output logic            load_acc,
    output logic            alu_enable,
    output logic            alu_sub,
    output logic [3:0]      imm,
    output logic            halted,
    output logic            fault,
    output logic [7:0]      instr_count
);

    localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT);

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic [PC_W-1:0]   jump_target;
    logic [3:0]        fetch_op;

    assign wait_inc    = wait_cnt + 1'b1;
    assign jump_target = PC_W'(ir[3:0]);
    assign fetch_op    = mem_rdata[7:4];
    // pc is a register, so the address is as clean as any registered output
    assign mem_addr    = pc;

    // Strobes and imm are decoded from mem_rdata on the accepting FETCH edge
    // so that they are registered and valid for exactly the EXEC cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            mem_req     <= 1'b0;
            load_acc    <= 1'b0;
            alu_enable  <= 1'b0;
            alu_sub     <= 1'b0;
            imm         <= '0;
            halted      <= 1'b1;
            fault       <= 1'b0;
        end else begin
            load_acc   <= 1'b0;
            alu_enable <= 1'b0;
            alu_sub    <= 1'b0;
            imm        <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        state    <= S_EXEC;
                        ir       <= mem_rdata;
                        pc       <= pc + 1'b1;
                        wait_cnt <= '0;
                        mem_req  <= 1'b0;
                        imm      <= mem_rdata[3:0];
                        case (fetch_op)
                            OP_LDI:  load_acc <= 1'b1;
                            OP_ADD:  alu_enable <= 1'b1;
                            OP_SUB: begin
                                alu_enable <= 1'b1;
                                alu_sub    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_LIMIT) begin
                            state   <= S_FAULT;
                            mem_req <= 1'b0;
                            fault   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    instr_count <= instr_count + 8'd1;
                    case (ir[7:4])
                        OP_JMP: pc <= jump_target;
                        OP_JZ: begin
                            if (zero) begin
                                pc <= jump_target;
                            end
                        end
                        default: ;
                    endcase
                    if (ir[7:4] == OP_HLT) begin
                        state  <= S_IDLE;
                        halted <= 1'b1;
                    end else begin
                        state   <= S_FETCH;
                        mem_req <= 1'b1;
                    end
                end
                S_FAULT: ;
                default: state <= S_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer
module tb_instruction_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       zero;
    logic       load_acc;
    logic       alu_enable;
    logic       alu_sub;
    logic [3:0] imm;
    logic       halted;
    logic       fault;
    logic [7:0] instr_count;

    instruction_sequencer #(.PC_W(4), .ACK_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .zero        (zero),
        .load_acc    (load_acc),
        .alu_enable  (alu_enable),
        .alu_sub     (alu_sub),
        .imm         (imm),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    logic       zero_tab [16];
    logic [3:0] exp_addr [$];
    logic [6:0] exp_exec [$];
    int         ack_delay;
    int         wait_ctr;
    int         req_cycles;
    bit         exec_pending;
    bit         fault_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe DUT just after the edge, then act as program memory.
    task automatic step();
        logic [6:0] e;
        @(posedge clk);
        #1;
        if (mem_req) req_cycles++;
        if (fault) fault_seen = 1'b1;
        if (exec_pending) begin
            exec_pending = 1'b0;
            check_eq("exec_q_nonempty", (exp_exec.size() > 0), 1);
            if (exp_exec.size() > 0) begin
                e = exp_exec.pop_front();
                check_eq("exec_strobes", {load_acc, alu_enable, alu_sub, imm}, e);
            end
        end else begin
            check_eq("quiet_strobes", {load_acc, alu_enable, alu_sub, imm}, 0);
        end
        if (mem_req) begin
            if (exp_addr.size() == 0) check_eq("unexpected_fetch", mem_addr, 32'hFFFF);
            else check_eq("fetch_addr", mem_addr, exp_addr[0]);
            if (ack_delay >= 0 && wait_ctr == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                zero      = zero_tab[mem_addr];
                if (exp_addr.size() > 0) void'(exp_addr.pop_front());
                exec_pending = 1'b1;
                wait_ctr     = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wait_ctr++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            wait_ctr  = 0;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 8'h00;
            zero_tab[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        exec_pending = 1'b0;
        wait_ctr     = 0;
        req_cycles   = 0;
        fault_seen   = 1'b0;
        exp_addr.delete();
        exp_exec.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check_eq("halt_reached", halted, 1);
        check_eq("queues_drained", exp_addr.size() + exp_exec.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; zero = 1'b0;
        ack_delay = 0;
        clear_mem();
        do_reset();

        // reset state
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_strobes", {load_acc, alu_enable, alu_sub, imm}, 0);
        check_eq("rst_halted", halted, 1);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_count", instr_count, 0);
        check_eq("rst_pc", mem_addr, 0);

        // LDI 5, ADD 3, HLT with immediate ack
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'hF0;
        exp_addr = '{4'd0, 4'd1, 4'd2};
        exp_exec = '{7'b100_0101, 7'b010_0011, 7'b000_0000};
        pulse_start();
        run_to_halt(40);
        check_eq("t1_count", instr_count, 3);
        check_eq("t1_pc", mem_addr, 3);
        check_eq("t1_fault", fault, 0);

        // ack delayed 4 cycles on every fetch
        do_reset(); clear_mem();
        ack_delay = 4;
        mem[0] = 8'h12; mem[1] = 8'hF0;
        exp_addr = '{4'd0, 4'd1};
        exp_exec = '{7'b100_0010, 7'b000_0000};
        pulse_start();
        run_to_halt(60);
        check_eq("t2_req_cycles", req_cycles, 10);
        check_eq("t2_fault_seen", fault_seen, 0);
        check_eq("t2_count", instr_count, 2);

        // ack on the final permitted FETCH cycle beats the timeout
        do_reset(); clear_mem();
        ack_delay = 14;
        mem[0] = 8'h15; mem[1] = 8'hF0;
        exp_addr = '{4'd0, 4'd1};
        exp_exec = '{7'b100_0101, 7'b000_0000};
        pulse_start();
        run_to_halt(80);
        check_eq("t3_fault_seen", fault_seen, 0);
        check_eq("t3_req_cycles", req_cycles, 30);

        // JZ taken, JZ not taken, SUB, HLT
        do_reset(); clear_mem();
        ack_delay = 0;
        mem[0] = 8'h8A; zero_tab[0] = 1'b1;
        mem[10] = 8'h8C; zero_tab[10] = 1'b0;
        mem[11] = 8'h37; mem[12] = 8'hF0;
        exp_addr = '{4'd0, 4'd10, 4'd11, 4'd12};
        exp_exec = '{7'b000_1010, 7'b000_1100, 7'b011_0111, 7'b000_0000};
        pulse_start();
        run_to_halt(40);
        check_eq("t4_count", instr_count, 4);
        check_eq("t4_pc", mem_addr, 13);

        // JMP to 15, HLT at 15 wraps pc to 0; resume with JMP at 15
        do_reset(); clear_mem();
        mem[0] = 8'h7F; mem[15] = 8'hF0;
        exp_addr = '{4'd0, 4'd15};
        exp_exec = '{7'b000_1111, 7'b000_0000};
        pulse_start();
        run_to_halt(40);
        check_eq("t5a_pc_wrap", mem_addr, 0);
        mem[0] = 8'h7E; mem[14] = 8'h00; mem[15] = 8'h71; mem[1] = 8'hF0;
        exp_addr = '{4'd0, 4'd14, 4'd15, 4'd1};
        exp_exec = '{7'b000_1110, 7'b000_0000, 7'b000_0001, 7'b000_0000};
        pulse_start();
        run_to_halt(40);
        check_eq("t5b_pc", mem_addr, 2);
        check_eq("t5b_count", instr_count, 6);
        check_eq("t5b_fault_seen", fault_seen, 0);

        // ack never returned
        do_reset(); clear_mem();
        ack_delay = -1;
        exp_addr = '{4'd0};
        pulse_start();
        for (int n = 0; n < 40 && !fault; n++) step();
        check_eq("t6_fault", fault, 1);
        check_eq("t6_req_cycles", req_cycles, 15);
        check_eq("t6_mem_req", mem_req, 0);
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check_eq("t6_sticky_fault", fault, 1);
        check_eq("t6_start_ignored", {mem_req, halted}, 0);
        do_reset();
        check_eq("t6_reset_halted", halted, 1);
        check_eq("t6_reset_fault", fault, 0);

        // reset mid-FETCH while a late ack arrives
        clear_mem();
        ack_delay = 0;
        mem[0] = 8'h11; mem[1] = 8'hF0;
        exp_addr = '{4'd0, 4'd1};
        exp_exec = '{7'b100_0001, 7'b000_0000};
        pulse_start();
        run_to_halt(40);
        check_eq("t7_pc_before", mem_addr, 2);
        ack_delay = -1;
        exp_addr = '{4'd2};
        pulse_start();
        step(); step();
        check_eq("t7_mid_fetch", mem_req, 1);
        rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h15;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("t7_halted", halted, 1);
        check_eq("t7_req", mem_req, 0);
        check_eq("t7_pc", mem_addr, 0);
        check_eq("t7_count", instr_count, 0);
        @(posedge clk); #1;
        check_eq("t7_ack_ignored", {mem_req, load_acc, alu_enable, alu_sub, imm}, 0);
        check_eq("t7_still_idle", halted, 1);
        mem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
